// File: rtl/event_filter_scheduler.sv
// rtl/event_filter_scheduler.sv - round-robin scheduler sharing one moving-average event filter
//
// Grants whole contiguous bursts from NUM_REQ event sources to a single external
// W-deep moving-average filter, returns filter results only for windows that hold
// events of one owner, and flushes the filter window between owners.
//
// Optional feature macro: BURST_LIMIT_EN
//   defined   : a burst ends after MAX_BURST accepted events
//   undefined : the owner keeps the filter until its req_valid drops
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active HIGH (legacy name)
//   ena        new grants allowed
//   req_valid  per-requester event valid
//   req_data   per-requester event {t,y,x}, slice i = [6i+5:6i]
//   req_ready  one-hot ready toward the current owner
//   flt_ui     filter input {p[1:0],t,y,x}, driven every cycle
//   flt_uo     filter output, [5:0] = {sum_t,sum_y,sum_x}
//   res_valid  one-cycle result strobe
//   res_data   captured filter sums
//   res_owner  requester index that owns res_data
//   busy       scheduler not idle

module event_filter_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WINDOW_SIZE = 4,
  parameter int MAX_BURST   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [6*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           flt_ui,
  input  logic [7:0]           flt_uo,
  output logic                 res_valid,
  output logic [5:0]           res_data,
  output logic [2:0]           res_owner,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam int FW = $clog2(WINDOW_SIZE + 1);

`ifdef BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]    state;
  logic [2:0]    rr_ptr;
  logic [2:0]    owner;
  logic [CW-1:0] fill;
  logic [CW-1:0] burst;
  logic [FW-1:0] cnt;
  logic          pend;

  logic [7:0]    valid_pad;
  logic [47:0]   data_pad;
  logic [5:0]    ev [8];
  logic          accept;
  logic          grant_found;
  logic [2:0]    grant_idx;
  logic [3:0]    cand;

  // Top filter output bits carry nothing for this block.
  logic          unused_flt_hi;
  assign unused_flt_hi = ^flt_uo[7:6];

  // Pad requester vectors to 8 entries so a 3-bit owner can index them directly.
  assign valid_pad = 8'(req_valid);
  assign data_pad  = 48'(req_data);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ev[i] = data_pad[6*i +: 6];
    end
  end

  assign accept = (state == S_STREAM) && valid_pad[owner];
  assign busy   = (state != S_IDLE);

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!grant_found && valid_pad[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == S_STREAM) && (owner == 3'(i));
    end
  end

  // The filter shifts every clock, so something is presented every cycle.
  // p=2'b11 is kept for the cycle after the last accept so its sums are captured.
  always_comb begin
    flt_ui = 8'h00;
    case (state)
      S_STREAM: flt_ui = accept ? {2'b11, ev[owner]} : 8'hC0;
      S_DRAIN:  flt_ui = 8'hC0;
      default:  flt_ui = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 3'd0;
      owner     <= 3'd0;
      fill      <= '0;
      burst     <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 6'd0;
      res_owner <= 3'd0;
    end else begin
      // Sums for an event accepted last cycle are visible on flt_uo this cycle.
      pend      <= accept;
      res_valid <= pend && (fill >= CW'(WINDOW_SIZE));
      if (pend) begin
        res_data  <= flt_uo[5:0];
        res_owner <= owner;
      end

      case (state)
        S_IDLE: begin
          if (ena && grant_found) begin
            owner  <= grant_idx;
            rr_ptr <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
            fill   <= '0;
            burst  <= '0;
            state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            if (fill < CW'(WINDOW_SIZE)) begin
              fill <= fill + 1'b1;
            end
            if (burst != '1) begin
              burst <= burst + 1'b1;
            end
            if (LIMIT && (burst == CW'(MAX_BURST - 1))) begin
              state <= S_DRAIN;
            end
          end else begin
            // Bursts are contiguous: the first gap ends the grant.
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_FLUSH;
          cnt   <= FW'(WINDOW_SIZE);
        end
        default: begin
          if (cnt <= FW'(1)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_filter_scheduler.sv
// tb/tb_event_filter_scheduler.sv - self-checking bench for event_filter_scheduler

module tb_event_filter_scheduler;

  localparam int NR = 4;
  localparam int WS = 4;
  localparam int MB = 8;

`ifdef BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  flt_ui;
  logic [7:0]  flt_uo;
  logic        res_valid;
  logic [5:0]  res_data;
  logic [2:0]  res_owner;
  logic        busy;

  always #5 clk = ~clk;

  event_filter_scheduler #(.NUM_REQ(NR), .WINDOW_SIZE(WS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst), .ena(ena), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flt_ui(flt_ui), .flt_uo(flt_uo), .res_valid(res_valid),
    .res_data(res_data), .res_owner(res_owner), .busy(busy)
  );

  // Filter: W-deep window shifting every clock, 2-bit modulo sums, gated by p==2'b11.
  logic [5:0] win [WS];
  logic [1:0] fsx, fsy, fst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WS; i++) win[i] <= '0;
    end else begin
      win[0] <= flt_ui[5:0];
      for (int i = 1; i < WS; i++) win[i] <= win[i-1];
    end
  end
  always_comb begin
    fsx = '0; fsy = '0; fst = '0;
    for (int i = 0; i < WS; i++) begin
      fsx = fsx + win[i][1:0];
      fsy = fsy + win[i][3:2];
      fst = fst + win[i][5:4];
    end
    flt_uo = (flt_ui[7:6] == 2'b11) ? {2'b00, fst, fsy, fsx} : 8'h00;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction-level view of grants, tails and results.
  typedef struct { int due; logic [5:0] data; int owner; } res_t;
  bit          m_stream = 0;
  int          m_owner = 0;
  int          m_acc = 0;
  int          m_rr = 0;
  int          cyc = 0;
  logic [7:0]  tailq [$];
  logic [5:0]  evq [$];
  res_t        rq [$];

  // Observations of DUT behaviour for directed scenario checks.
  int grants [$];
  int bursts [$];
  bit in_run = 0;
  int run_acc = 0;
  int obs_res_cnt = 0;
  logic [5:0] obs_last_data = '0;
  int obs_last_owner = 0;
  int obs_by_owner [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [5:0] win_sum();
    int sx = 0, sy = 0, st = 0;
    for (int i = evq.size() - WS; i < evq.size(); i++) begin
      sx += int'(evq[i][1:0]);
      sy += int'(evq[i][3:2]);
      st += int'(evq[i][5:4]);
    end
    return {2'(st % 4), 2'(sy % 4), 2'(sx % 4)};
  endfunction

  task automatic end_burst();
    m_stream = 0;
    tailq.push_back(8'hC0);
    for (int i = 0; i < WS; i++) tailq.push_back(8'h00);
  endtask

  task automatic clear_obs();
    grants.delete();
    bursts.delete();
    obs_res_cnt = 0;
    for (int i = 0; i < 8; i++) obs_by_owner[i] = 0;
  endtask

  task automatic check_cycle();
    logic [3:0] er;
    logic [7:0] ef;
    logic       eb;
    logic [5:0] ev;
    res_t       r;
    er = '0; ef = '0; eb = 1'b0;
    if (m_stream) begin
      eb = 1'b1;
      er = 4'(1 << m_owner);
      if (req_valid[m_owner]) begin
        ev = req_data[6*m_owner +: 6];
        ef = {2'b11, ev};
        evq.push_back(ev);
        m_acc++;
        if (m_acc >= WS) rq.push_back('{cyc + 2, win_sum(), m_owner});
        if (LIM && m_acc == MB) end_burst();
      end else begin
        ef = 8'hC0;
        end_burst();
      end
    end else if (tailq.size() > 0) begin
      eb = 1'b1;
      ef = tailq.pop_front();
    end else if (ena && req_valid != 0) begin
      for (int k = 0; k < NR; k++) begin
        if (req_valid[(m_rr + k) % NR]) begin
          m_owner = (m_rr + k) % NR;
          break;
        end
      end
      m_rr = (m_owner + 1) % NR;
      m_stream = 1;
      m_acc = 0;
      evq.delete();
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("flt_ui", 32'(flt_ui), 32'(ef));
    chk("busy", 32'(busy), 32'(eb));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_data", 32'(res_data), 32'(r.data));
      chk("res_owner", 32'(res_owner), 32'(r.owner));
    end else begin
      chk("res_valid_idle", 32'(res_valid), 32'd0);
    end
    if (res_valid) begin
      obs_res_cnt++;
      obs_last_data = res_data;
      obs_last_owner = int'(res_owner);
      obs_by_owner[res_owner]++;
    end
    if (req_ready != 0) begin
      if (!in_run) begin
        for (int k = 0; k < NR; k++) if (req_ready[k]) grants.push_back(k);
        in_run = 1;
        run_acc = 0;
      end
      if ((req_ready & req_valid) != 0) run_acc++;
    end else if (in_run) begin
      bursts.push_back(run_acc);
      in_run = 0;
    end
    cyc++;
  endtask

  task automatic step(input logic [3:0] v, input logic [23:0] d, input logic e);
    @(posedge clk);
    #1;
    req_valid = v;
    req_data = d;
    ena = e;
    @(negedge clk);
    check_cycle();
  endtask

  function automatic logic [23:0] rnd();
    return 24'($urandom());
  endfunction

  task automatic model_reset();
    m_stream = 0; m_owner = 0; m_acc = 0; m_rr = 0;
    tailq.delete(); evq.delete(); rq.delete();
    in_run = 0; run_acc = 0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    ena = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_flt_ui", 32'(flt_ui), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rel_busy", 32'(busy), 32'd0);
  endtask

  logic [3:0] rv;

  initial begin
    // Power-on reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_ready", 32'(req_ready), 32'd0);
    chk("por_flt_ui", 32'(flt_ui), 32'd0);
    chk("por_res_valid", 32'(res_valid), 32'd0);
    chk("por_res_data", 32'(res_data), 32'd0);
    chk("por_res_owner", 32'(res_owner), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_reset();

    // 1: reset in the middle of a stream.
    step(4'b0001, rnd(), 1'b1);
    repeat (3) step(4'b0001, rnd(), 1'b1);
    mid_reset();

    // 2: four back-to-back events from req0.
    clear_obs();
    step(4'b0001, 24'h0, 1'b1);
    step(4'b0001, 24'h000001, 1'b1);
    step(4'b0001, 24'h000001, 1'b1);
    step(4'b0001, 24'h000000, 1'b1);
    step(4'b0001, 24'h000001, 1'b1);
    repeat (10) step(4'b0000, rnd(), 1'b1);
    chk("t2_res_count", 32'(obs_res_cnt), 32'd1);
    chk("t2_res_data", 32'(obs_last_data), 32'h03);
    chk("t2_res_owner", 32'(obs_last_owner), 32'd0);

    // 3: req1 and req3 continuously valid.
    clear_obs();
    repeat (60) step(4'b1010, rnd(), 1'b1);
    repeat (15) step(4'b0000, rnd(), 1'b1);
    chk("t3_first_grant", 32'(grants[0]), 32'd1);
    if (LIM) begin
      chk("t3_grant_count", 32'(grants.size()), 32'd5);
      chk("t3_grant1", 32'(grants[1]), 32'd3);
      chk("t3_grant2", 32'(grants[2]), 32'd1);
      chk("t3_grant3", 32'(grants[3]), 32'd3);
      chk("t3_burst0", 32'(bursts[0]), 32'd8);
    end else begin
      chk("t3_grant_count", 32'(grants.size()), 32'd1);
    end

    // 4: req2 valid for 20 cycles.
    clear_obs();
    repeat (20) step(4'b0100, rnd(), 1'b1);
    repeat (15) step(4'b0000, rnd(), 1'b1);
    chk("t4_burst0", 32'(bursts[0]), LIM ? 32'd8 : 32'd19);

    // 5: req0 drops after two accepts, req1 follows.
    clear_obs();
    step(4'b0001, rnd(), 1'b1);
    repeat (2) step(4'b0001, rnd(), 1'b1);
    repeat (20) step(4'b0010, rnd(), 1'b1);
    repeat (15) step(4'b0000, rnd(), 1'b1);
    chk("t5_burst0", 32'(bursts[0]), 32'd2);
    chk("t5_owner0_results", 32'(obs_by_owner[0]), 32'd0);
    chk("t5_owner1_results", 32'(obs_by_owner[1]), LIM ? 32'd5 : 32'd10);

    // 6: ena low blocks grants; then one long stream from req3.
    clear_obs();
    repeat (8) step(4'b1111, rnd(), 1'b0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_grant", 32'(grants.size()), 32'd0);
    repeat (21) step(4'b1000, rnd(), 1'b1);
    repeat (15) step(4'b0000, rnd(), 1'b1);
    chk("t6_burst0", 32'(bursts[0]), LIM ? 32'd8 : 32'd20);

    // Randomised traffic with sticky per-requester valids and occasional ena drops.
    rv = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
      end
      step(rv, rnd(), ($urandom_range(0, 7) != 0));
    end
    repeat (20) step(4'b0000, rnd(), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
